// File: rtl/hx8352_pkg.sv
// Shared constants and types for the HX8352 rectangle-fill path.
package hx8352_pkg;

  localparam int unsigned XMaxDefault = 239;
  localparam int unsigned YMaxDefault = 399;

  // Window registers: each coordinate is split into a high bit and a low byte.
  localparam logic [7:0] RegX0Hi   = 8'h02;
  localparam logic [7:0] RegX0Lo   = 8'h03;
  localparam logic [7:0] RegX1Hi   = 8'h04;
  localparam logic [7:0] RegX1Lo   = 8'h05;
  localparam logic [7:0] RegY0Hi   = 8'h06;
  localparam logic [7:0] RegY0Lo   = 8'h07;
  localparam logic [7:0] RegY1Hi   = 8'h08;
  localparam logic [7:0] RegY1Lo   = 8'h09;
  localparam logic [7:0] RegGramWr = 8'h22;

  // Phases 0..15 are the window register command/data pairs.
  localparam logic [4:0] PhaseGramCmd = 5'd16;
  localparam logic [4:0] PhasePixel   = 5'd17;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StGuard,
    StWait,
    StDone,
    StReject
  } state_e;

  // Register index for window register pair 0..7.
  function automatic logic [7:0] reg_index(input logic [2:0] pair);
    logic [7:0] idx;
    unique case (pair)
      3'd0:    idx = RegX0Hi;
      3'd1:    idx = RegX0Lo;
      3'd2:    idx = RegX1Hi;
      3'd3:    idx = RegX1Lo;
      3'd4:    idx = RegY0Hi;
      3'd5:    idx = RegY0Lo;
      3'd6:    idx = RegY1Hi;
      default: idx = RegY1Lo;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/hx8352_rect_pixel_counter.sv
// Nested column/row pixel counter over an inclusive window; flags the last pixel.
module hx8352_rect_pixel_counter
  import hx8352_pkg::*;
#(
  parameter int unsigned CW = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] x0_i,
  input  logic [CW-1:0] x1_i,
  input  logic [CW-1:0] y0_i,
  input  logic [CW-1:0] y1_i,
  input  logic          advance_i,
  output logic          last_o
);

  logic [CW-1:0] col_q;
  logic [CW-1:0] row_q;

  // Column steps x0..x1, wrapping to x0 and bumping the row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (load_i) begin
      col_q <= x0_i;
      row_q <= y0_i;
    end else if (advance_i) begin
      if (col_q == x1_i) begin
        col_q <= x0_i;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign last_o = (col_q == x1_i) && (row_q == y1_i);

endmodule

// File: rtl/hx8352_fill_sequencer.sv
// Rectangle-fill scheduler: programs the HX8352 window, issues GRAM write, then
// streams one colour word per pixel. Optional build macro HX8352_FILL_CLIP_EN
// clamps captured coordinates to X_MAX/Y_MAX.
module hx8352_fill_sequencer
  import hx8352_pkg::*;
#(
  parameter int unsigned X_MAX = XMaxDefault,
  parameter int unsigned Y_MAX = YMaxDefault,
  parameter int unsigned CW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_done,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_x0,
  input  logic [CW-1:0] req_x1,
  input  logic [CW-1:0] req_y0,
  input  logic [CW-1:0] req_y1,
  input  logic [15:0]   req_color,
  output logic [15:0]   bus_data,
  output logic          bus_dc,
  output logic          bus_step,
  input  logic          bus_busy,
  output logic          busy,
  output logic          done,
  output logic          err
);

`ifdef HX8352_FILL_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  localparam logic [CW-1:0] XLim = CW'(X_MAX);
  localparam logic [CW-1:0] YLim = CW'(Y_MAX);

  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] c, input logic [CW-1:0] lim);
    return (ClipEn && (c > lim)) ? lim : c;
  endfunction

  state_e        state_q, state_d;
  logic [4:0]    phase_q, phase_d;
  logic          last_sent_q, last_sent_d;
  logic [CW-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [15:0]   color_q;
  logic [15:0]   bus_data_q, bus_data_d;
  logic          bus_dc_q, bus_dc_d;
  logic          bus_step_q, busy_q, done_q, err_q;
  logic          accept;
  logic          pix_load, pix_advance, pix_last;
  logic [15:0]   word;
  logic          word_dc;
  logic [CW-1:0] coord;

  assign req_ready = (state_q == StIdle) && init_done;
  assign accept    = req_valid && req_ready;

  hx8352_rect_pixel_counter #(
    .CW (CW)
  ) u_pix_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (pix_load),
    .x0_i      (x0_q),
    .x1_i      (x1_q),
    .y0_i      (y0_q),
    .y1_i      (y1_q),
    .advance_i (pix_advance),
    .last_o    (pix_last)
  );

  // Capture the request once; later input changes have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (accept) begin
      x0_q    <= clamp(req_x0, XLim);
      x1_q    <= clamp(req_x1, XLim);
      y0_q    <= clamp(req_y0, YLim);
      y1_q    <= clamp(req_y1, YLim);
      color_q <= req_color;
    end
  end

  // Word for the transfer selected by the current phase.
  always_comb begin
    word    = '0;
    word_dc = 1'b0;
    coord   = '0;
    if (phase_q == PhasePixel) begin
      word    = color_q;
      word_dc = 1'b1;
    end else if (phase_q == PhaseGramCmd) begin
      word = {8'h00, RegGramWr};
    end else if (!phase_q[0]) begin
      word = {8'h00, reg_index(phase_q[3:1])};
    end else begin
      word_dc = 1'b1;
      unique case (phase_q[3:2])
        2'd0:    coord = x0_q;
        2'd1:    coord = x1_q;
        2'd2:    coord = y0_q;
        default: coord = y1_q;
      endcase
      word = phase_q[1] ? {8'h00, coord[7:0]} : 16'(coord >> 8);
    end
  end

  // Next-state, phase tracking and bus word latch.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    last_sent_d = last_sent_q;
    bus_data_d  = bus_data_q;
    bus_dc_d    = bus_dc_q;
    pix_load    = 1'b0;
    pix_advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StCheck;
          phase_d     = '0;
          last_sent_d = 1'b0;
        end
      end
      StCheck: begin
        if ((x0_q > x1_q) || (y0_q > y1_q)) begin
          state_d = StReject;
        end else begin
          state_d  = StIssue;
          pix_load = 1'b1;
        end
      end
      StIssue: begin
        state_d = StGuard;
        if (phase_q == PhasePixel) begin
          last_sent_d = pix_last;
          pix_advance = 1'b1;
        end else begin
          phase_d = phase_q + 5'd1;
        end
      end
      // bus_busy lags bus_step, so it is not trusted here.
      StGuard: state_d = StWait;
      StWait: begin
        if (!bus_busy) begin
          state_d = ((phase_q == PhasePixel) && last_sent_q) ? StDone : StIssue;
        end
      end
      StDone:   state_d = StIdle;
      StReject: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Bus word changes only on entry to ISSUE and holds until the next one.
    if (state_d == StIssue) begin
      bus_data_d = word;
      bus_dc_d   = word_dc;
    end
  end

  // State and registered outputs; strobes line up with the state they mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      last_sent_q <= 1'b0;
      bus_data_q  <= '0;
      bus_dc_q    <= 1'b0;
      bus_step_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      last_sent_q <= last_sent_d;
      bus_data_q  <= bus_data_d;
      bus_dc_q    <= bus_dc_d;
      bus_step_q  <= (state_d == StIssue);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      err_q       <= (state_d == StReject);
    end
  end

  assign bus_data = bus_data_q;
  assign bus_dc   = bus_dc_q;
  assign bus_step = bus_step_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_hx8352_fill_sequencer.sv
// Scoreboard bench for hx8352_fill_sequencer: expected bus transfers are queued
// by the stimulus and popped by a monitor on every bus_step.
module tb_hx8352_fill_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [8:0]  req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
  logic [15:0] req_color = '0;
  logic [15:0] bus_data;
  logic        bus_dc, bus_step, bus_busy, busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_len = 0;
  int busy_cnt = 0;
  int step_cnt = 0;
  logic [16:0] exp_q[$];
  logic [16:0] log_q[$];

  hx8352_fill_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x0    (req_x0),
    .req_x1    (req_x1),
    .req_y0    (req_y0),
    .req_y1    (req_y1),
    .req_color (req_color),
    .bus_data  (bus_data),
    .bus_dc    (bus_dc),
    .bus_step  (bus_step),
    .bus_busy  (bus_busy),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy rises the cycle after a step and stays for busy_len cycles.
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (bus_step) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every transfer strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus_step) begin
      step_cnt++;
      log_q.push_back({bus_dc, bus_data});
      chk("no_step_while_busy", 32'(bus_busy), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_step", 32'({bus_dc, bus_data}), 32'hFFFF_FFFF);
      else chk("bus_transfer", 32'({bus_dc, bus_data}), 32'(exp_q.pop_front()));
    end
  end

  task automatic push_fill(input int x0, input int x1, input int y0, input int y1,
                           input logic [15:0] color, input int npix);
    int c[4];
    c = '{x0, x1, y0, y1};
`ifdef HX8352_FILL_CLIP_EN
    if (c[0] > 239) c[0] = 239;
    if (c[1] > 239) c[1] = 239;
    if (c[2] > 399) c[2] = 399;
    if (c[3] > 399) c[3] = 399;
`endif
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 16'(2 + 2 * i)});
      exp_q.push_back({1'b1, 16'(c[i] >> 8)});
      exp_q.push_back({1'b0, 16'(3 + 2 * i)});
      exp_q.push_back({1'b1, 16'(c[i] & 255)});
    end
    exp_q.push_back({1'b0, 16'h0022});
    for (int i = 0; i < npix; i++) exp_q.push_back({1'b1, color});
  endtask

  task automatic do_req(input logic [8:0] x0, input logic [8:0] x1, input logic [8:0] y0,
                        input logic [8:0] y1, input logic [15:0] color, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk("req_ready_seen", 32'(req_ready), 32'd1);
    req_x0 = x0; req_x1 = x1; req_y0 = y0; req_y1 = y1; req_color = color;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    // Scramble inputs; the block must work from its captured copy.
    req_x0 = 9'h1AA; req_x1 = 9'h055; req_y0 = 9'h1F0; req_y1 = 9'h00F; req_color = 16'hDEAD;
  endtask

  task automatic wait_done(input int acc, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, s, dcnt;

    // Reset values.
    #12;
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_bus_dc", 32'(bus_dc), 32'd0);
    chk("rst_bus_step", 32'(bus_step), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    #10 rst = 1'b0;

    // No accept while init is incomplete.
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("noinit_ready", 32'(req_ready), 32'd0);
    chk("noinit_busy", 32'(busy), 32'd0);
    req_valid = 1'b0;
    init_done = 1'b1;

    // 1x1 fill at origin. DONE lands 55 edges after the accept edge
    // (accept cycle, CHECK, 18 transfers x 3, DONE = 57th cycle).
    log_q.delete();
    push_fill(0, 0, 0, 0, 16'hF800, 1);
    do_req(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800, acc);
    wait_done(acc, 200, lat);
    chk("fill1x1_latency", 32'(lat), 32'd55);
    chk("fill1x1_steps", 32'(log_q.size()), 32'd18);
    chk("fill1x1_queue_empty", 32'(exp_q.size()), 32'd0);
    if (log_q.size() == 18) begin
      chk("fill1x1_first", 32'(log_q[0]), 32'h0_0002);
      chk("fill1x1_gram_cmd", 32'(log_q[16]), 32'h0_0022);
      chk("fill1x1_pixel", 32'(log_q[17]), 32'h1_F800);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    // 4x2 fill, y0=300 -> 0x06 data 0x01, 0x07 data 0x2C.
    log_q.delete();
    push_fill(10, 13, 300, 301, 16'h1234, 8);
    do_req(9'd10, 9'd13, 9'd300, 9'd301, 16'h1234, acc);
    wait_done(acc, 500, lat);
    chk("fill4x2_latency", 32'(lat), 32'd76);
    chk("fill4x2_steps", 32'(log_q.size()), 32'd25);
    chk("fill4x2_queue_empty", 32'(exp_q.size()), 32'd0);
    if (log_q.size() > 11) begin
      chk("fill4x2_y0_hi", 32'(log_q[9]), 32'h1_0001);
      chk("fill4x2_y0_lo", 32'(log_q[11]), 32'h1_002C);
    end
    dcnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("fill4x2_single_done", 32'(dcnt), 32'd0);

    // Reject on x0 > x1: err two cycles in, no bus activity, ready next cycle.
    s = step_cnt;
    do_req(9'd20, 9'd10, 9'd0, 9'd0, 16'hFFFF, acc);
    @(posedge clk);
    #1;
    chk("rejx_err", 32'(err), 32'd1);
    chk("rejx_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rejx_err_pulse", 32'(err), 32'd0);
    chk("rejx_ready_back", 32'(req_ready), 32'd1);
    chk("rejx_idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rejx_no_steps", 32'(step_cnt - s), 32'd0);

    // Reject on y0 > y1.
    do_req(9'd0, 9'd0, 9'd5, 9'd4, 16'hFFFF, acc);
    @(posedge clk);
    #1;
    chk("rejy_err", 32'(err), 32'd1);

    // Busy held 5 cycles after each step: each transfer takes 7 cycles here.
    busy_len = 5;
    log_q.delete();
    push_fill(5, 6, 7, 7, 16'h0F0F, 2);
    do_req(9'd5, 9'd6, 9'd7, 9'd7, 16'h0F0F, acc);
    wait_done(acc, 1000, lat);
    chk("busy_latency", 32'(lat), 32'd134);
    chk("busy_queue_empty", 32'(exp_q.size()), 32'd0);
    busy_len = 0;

    // x1=300: clamped to 239 only in the clip build.
    log_q.delete();
`ifdef HX8352_FILL_CLIP_EN
    push_fill(0, 300, 0, 0, 16'hAAAA, 240);
`else
    push_fill(0, 300, 0, 0, 16'hAAAA, 301);
`endif
    do_req(9'd0, 9'd300, 9'd0, 9'd0, 16'hAAAA, acc);
    wait_done(acc, 3000, lat);
    chk("clip_queue_empty", 32'(exp_q.size()), 32'd0);
    if (log_q.size() > 7) begin
`ifdef HX8352_FILL_CLIP_EN
      chk("clip_x1_hi", 32'(log_q[5]), 32'h1_0000);
      chk("clip_x1_lo", 32'(log_q[7]), 32'h1_00EF);
`else
      chk("clip_x1_hi", 32'(log_q[5]), 32'h1_0001);
      chk("clip_x1_lo", 32'(log_q[7]), 32'h1_002C);
`endif
    end

    // Reset after 30 pixels of a full-screen fill.
    push_fill(0, 239, 0, 399, 16'h07E0, 40);
    s = step_cnt;
    do_req(9'd0, 9'd239, 9'd0, 9'd399, 16'h07E0, acc);
    for (int i = 0; i < 400 && (step_cnt - s) < 47; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_progress", 32'(step_cnt - s), 32'd47);
    rst = 1'b1;
    #1;
    chk("rstmid_bus_data", 32'(bus_data), 32'd0);
    chk("rstmid_bus_dc_step", 32'({bus_dc, bus_step}), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done_err", 32'({done, err}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    log_q.delete();
    push_fill(0, 0, 0, 0, 16'h001F, 1);
    do_req(9'd0, 9'd0, 9'd0, 9'd0, 16'h001F, acc);
    wait_done(acc, 200, lat);
    chk("after_rst_latency", 32'(lat), 32'd55);
    chk("after_rst_steps", 32'(log_q.size()), 32'd18);
    chk("after_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
